// File: rtl/fixed_priority_arbiter_pkg.sv
// Shared constants and helpers for the fixed-priority arbiter and its reference models.
package fixed_priority_arbiter_pkg;

    localparam int REQ_NUM_DEFAULT = 8;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Index of the set bit in a one-hot vector; 0 for an all-zero vector
    function automatic int onehot_to_idx(input logic [63:0] vec);
        int idx;
        idx = 0;
        for (int i = 0; i < 64; i++) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/fixed_priority_arbiter_lsb_select.sv
// Combinational lowest-set-bit isolator with binary encoder (module prio_lsb_select).
module prio_lsb_select
    import fixed_priority_arbiter_pkg::*;
#(
    parameter int REQ_NUM = REQ_NUM_DEFAULT,
    localparam int IDX_W = idx_width(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0] reqs,
    output logic [REQ_NUM-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    localparam logic [REQ_NUM-1:0] ONE = REQ_NUM'(1);

    logic [63:0] onehot_ext;

    // Two's-complement trick keeps only the lowest asserted request
    always_comb begin
        onehot     = reqs & (~reqs + ONE);
        onehot_ext = '0;
        onehot_ext[REQ_NUM-1:0] = onehot;
        idx        = IDX_W'(onehot_to_idx(onehot_ext));
        any        = |reqs;
    end

endmodule

// File: rtl/fixed_priority_arbiter.sv
// Registered fixed-priority arbiter, bit 0 highest priority.
// Define PRIO_ARB_HOLD_EN to keep a grant until its request drops (non-preemptive).
module fixed_priority_arbiter
    import fixed_priority_arbiter_pkg::*;
#(
    parameter int REQ_NUM = REQ_NUM_DEFAULT,
    localparam int IDX_W = idx_width(REQ_NUM)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [REQ_NUM-1:0] reqs,
    output logic [REQ_NUM-1:0] grants,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [REQ_NUM-1:0] sel_onehot;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_any;

    logic [REQ_NUM-1:0] grants_d, grants_q;
    logic               grant_valid_d, grant_valid_q;
    logic [IDX_W-1:0]   grant_idx_d, grant_idx_q;

    prio_lsb_select #(.REQ_NUM(REQ_NUM)) u_select (
        .reqs   (reqs),
        .onehot (sel_onehot),
        .idx    (sel_idx),
        .any    (sel_any)
    );

    always_comb begin
        grants_d      = sel_onehot;
        grant_idx_d   = sel_idx;
        grant_valid_d = sel_any;
`ifdef PRIO_ARB_HOLD_EN
        // Current owner keeps the grant while it still requests
        if (|(grants_q & reqs)) begin
            grants_d      = grants_q;
            grant_idx_d   = grant_idx_q;
            grant_valid_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grants_q      <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
        end else begin
            grants_q      <= grants_d;
            grant_valid_q <= grant_valid_d;
            grant_idx_q   <= grant_idx_d;
        end
    end

    assign grants      = grants_q;
    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;

endmodule

// File: tb/tb_fixed_priority_arbiter.sv
// Directed and random self-checking bench for fixed_priority_arbiter (REQ_NUM=8).
module tb_fixed_priority_arbiter;
    import fixed_priority_arbiter_pkg::*;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] reqs;
    logic [N-1:0] grants;
    logic         grant_valid;
    logic [2:0]   grant_idx;

    int total;
    int bad;

    fixed_priority_arbiter #(.REQ_NUM(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .reqs        (reqs),
        .grants      (grants),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] eg, input logic ev, input logic [2:0] ei);
        check({tag, ".grants"}, 64'(grants), 64'(eg));
        check({tag, ".valid"}, 64'(grant_valid), 64'(ev));
        check({tag, ".idx"}, 64'(grant_idx), 64'(ei));
    endtask

    // Drive reqs between edges, then sample 1 time unit after the next rising edge
    task automatic step(input logic [7:0] v);
        reqs = v;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_g;
    logic [7:0] r;
    logic [7:0] lsb;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        reqs  = '0;

        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset", 8'h00, 1'b0, 3'd0);

        reqs = 8'h04;
        #2 rst_n = 1'b1;
        #1 check_all("release_before_edge", 8'h00, 1'b0, 3'd0);
        @(posedge clk);
        #1 check_all("first_grant", 8'h04, 1'b1, 3'd2);

        #2 rst_n = 1'b0;
        #1 check_all("async_reset", 8'h00, 1'b0, 3'd0);
        @(posedge clk);
        #1 check_all("reset_held", 8'h00, 1'b0, 3'd0);
        rst_n = 1'b1;
        #1 check_all("release_again", 8'h00, 1'b0, 3'd0);
        @(posedge clk);
        #1 check_all("regrant", 8'h04, 1'b1, 3'd2);

        step(8'hA8); check_all("multi_A8", 8'h08, 1'b1, 3'd3);
        step(8'h80); check_all("single_80", 8'h80, 1'b1, 3'd7);
        step(8'hFF); check_all("all_ones", 8'h01, 1'b1, 3'd0);
        step(8'h00); check_all("idle", 8'h00, 1'b0, 3'd0);

        step(8'h10); check_all("lat_first", 8'h10, 1'b1, 3'd4);
        reqs = 8'h02;
        #3 check_all("lat_between", 8'h10, 1'b1, 3'd4);
        @(posedge clk);
        #1 check_all("lat_after", 8'h02, 1'b1, 3'd1);

        step(8'h08); check_all("hold_setup", 8'h08, 1'b1, 3'd3);
        step(8'h09);
`ifdef PRIO_ARB_HOLD_EN
        check_all("hold_keep", 8'h08, 1'b1, 3'd3);
`else
        check_all("preempt", 8'h01, 1'b1, 3'd0);
`endif
        step(8'h01); check_all("hold_release", 8'h01, 1'b1, 3'd0);

        step(8'h00);
        exp_g = 8'h00;
        for (int i = 0; i < 1000; i++) begin
            r   = 8'($urandom);
            lsb = r & (~r + 8'd1);
`ifdef PRIO_ARB_HOLD_EN
            if ((exp_g & r) == 8'h00) exp_g = lsb;
`else
            exp_g = lsb;
`endif
            step(r);
            check("rand.grants", 64'(grants), 64'(exp_g));
            check("rand.onehot0", 64'($onehot0(grants)), 64'd1);
            check("rand.valid", 64'(grant_valid), 64'(r != 8'h00));
            check("rand.idx", 64'(grant_idx), 64'(onehot_to_idx(64'(exp_g))));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
